// File: rtl/fpu_pkg.sv
// Shared definitions for the FP operation sequencer: state and opcode
// encodings, result selector codes, counter limits and small helpers.
// Optional feature macro: FPU_SEQ_MUL_EN (enables FMUL sequencing).
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_NORM   = 3'd4,
    ST_ROUND  = 3'd5,
    ST_WB     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_FADD = 2'b00,
    OP_FSUB = 2'b01,
    OP_FMUL = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RES_NORMAL  = 2'b00,
    RES_SPECIAL = 2'b01,
    RES_ZERO    = 2'b10,
    RES_INVALID = 2'b11
  } res_e;

  localparam int ALIGN_CAP  = 25;
  localparam int NORM_MAX   = 24;
  localparam int MUL_CYCLES = 4;

  // Width of the align/norm counters (holds up to 25) and of the mul counter.
  localparam int CTR_W = 5;
  localparam int MUL_W = 3;

  // An opcode is accepted only if this build can sequence it.
  function automatic logic op_legal(input logic [1:0] op);
`ifdef FPU_SEQ_MUL_EN
    return op != OP_ILL;
`else
    return (op == OP_FADD) || (op == OP_FSUB);
`endif
  endfunction

  // Alignment never needs more than ALIGN_CAP shifts; larger differences
  // just flush the smaller operand into the sticky bits.
  function automatic logic [CTR_W-1:0] align_cap(input logic [7:0] diff);
    return (diff > 8'(ALIGN_CAP)) ? CTR_W'(ALIGN_CAP) : diff[CTR_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_seq_if.sv
// Handshake and datapath-status bundle between the FP datapath/host and
// the sequencer. The master drives requests and status; the sequencer
// (slave) drives the control strobes back.
interface fpu_seq_if;

  // Requests and datapath status
  logic       start;
  logic [1:0] op;
  logic       flush;
  logic       special;
  logic [7:0] exp_diff;
  logic       mant_msb;
  logic       mant_ovf;
  logic       mant_zero;

  // Sequencer controls
  logic       busy;
  logic       done;
  logic       unpack_en;
  logic       align_shift;
  logic       exec_en;
  logic       norm_left;
  logic       norm_right;
  logic       round_en;
  logic       wb_en;
  logic [1:0] result_sel;

  modport master (
    output start, op, flush, special, exp_diff, mant_msb, mant_ovf, mant_zero,
    input  busy, done, unpack_en, align_shift, exec_en, norm_left, norm_right,
           round_en, wb_en, result_sel
  );

  modport slave (
    input  start, op, flush, special, exp_diff, mant_msb, mant_ovf, mant_zero,
    output busy, done, unpack_en, align_shift, exec_en, norm_left, norm_right,
           round_en, wb_en, result_sel
  );

endinterface

// File: rtl/fpu_shift_ctr.sv
// Loadable up/down counter used for the align, norm and mul step counts.
// Priority: clear > load > increment (saturates at MAX) > decrement
// (stops at zero).
module fpu_shift_ctr #(
  parameter int WIDTH = 5,
  parameter int MAX   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero,
  output logic             o_sat
);

  logic [WIDTH-1:0] r_count;

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
  assign o_sat   = (r_count == WIDTH'(MAX));

  // Count register: clear/load/step with saturation at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// Control sequencer for a multi-cycle FP add/sub/mul datapath:
// IDLE -> UNPACK -> [ALIGN] -> EXEC -> NORM -> ROUND -> WB.
// Special operands, zero results and illegal opcodes short-cut to WB with
// the matching result selector. Flush aborts silently.
// Optional feature macro: FPU_SEQ_MUL_EN (FMUL support with a 4-cycle EXEC).
module fpu_seq
  import fpu_pkg::*;
(
  input logic      clk,
  input logic      reset,
  fpu_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_UNPACK = ST_UNPACK;
  localparam logic [2:0] S_ALIGN  = ST_ALIGN;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_NORM   = ST_NORM;
  localparam logic [2:0] S_ROUND  = ST_ROUND;
  localparam logic [2:0] S_WB     = ST_WB;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [1:0]       r_op;
  logic [1:0]       r_result_sel;
  logic [1:0]       w_result_next;

  logic             w_in_norm;
  logic             w_norm_left;
  logic             w_norm_right;

  logic [CTR_W-1:0] w_align_count;
  logic             w_align_zero;
  logic             w_align_sat;
  logic [CTR_W-1:0] w_norm_count;
  logic             w_norm_zero;
  logic             w_norm_sat;
  logic             w_unused;

`ifdef FPU_SEQ_MUL_EN
  logic [MUL_W-1:0] w_mul_count;
  logic             w_mul_zero;
  logic             w_mul_sat;
`endif

  // Normalisation decisions: zero beats overflow beats left shift.
  assign w_in_norm    = (r_state == S_NORM);
  assign w_norm_right = w_in_norm && !bus.mant_zero && bus.mant_ovf;
  assign w_norm_left  = w_in_norm && !bus.mant_zero && !bus.mant_ovf &&
                        !bus.mant_msb && !w_norm_sat;

  // Next state, and the result code latched on the way into WB.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    w_next        = r_state;
    w_result_next = RES_NORMAL;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (op_legal(bus.op)) begin
            w_next = S_UNPACK;
          end else begin
            w_next        = S_WB;
            w_result_next = RES_INVALID;
          end
        end
      end
      S_UNPACK: begin
        if (bus.special) begin
          w_next        = S_WB;
          w_result_next = RES_SPECIAL;
        end else if ((r_op == OP_FADD) || (r_op == OP_FSUB)) begin
          w_next = S_ALIGN;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_ALIGN: begin
        if (w_align_zero) w_next = S_EXEC;
      end
      S_EXEC: begin
`ifdef FPU_SEQ_MUL_EN
        if (!((r_op == OP_FMUL) && !w_mul_zero)) w_next = S_NORM;
`else
        w_next = S_NORM;
`endif
      end
      S_NORM: begin
        if (bus.mant_zero) begin
          w_next        = S_WB;
          w_result_next = RES_ZERO;
        end else if (!bus.mant_ovf && !w_norm_left) begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        w_next        = S_WB;
        w_result_next = RES_NORMAL;
      end
      S_WB: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (bus.flush && (r_state != S_IDLE)) begin
      w_next        = S_IDLE;
      w_result_next = RES_NORMAL;
    end
  end

  // State, captured opcode and result selector registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op         <= OP_FADD;
      r_result_sel <= RES_NORMAL;
    end else begin
      r_state      <= w_next;
      r_result_sel <= w_result_next;
      if ((r_state == S_IDLE) && bus.start) r_op <= bus.op;
    end
  end

  // Alignment shift count, loaded from the capped exponent difference.
  fpu_shift_ctr #(
    .WIDTH (CTR_W),
    .MAX   (ALIGN_CAP)
  ) u_align_ctr (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (1'b0),
    .i_load     (r_state == S_UNPACK),
    .i_load_val (align_cap(bus.exp_diff)),
    .i_inc      (1'b0),
    .i_dec      (r_state == S_ALIGN),
    .o_count    (w_align_count),
    .o_zero     (w_align_zero),
    .o_sat      (w_align_sat)
  );

  // Left-normalisation shift count; held clear outside NORM.
  fpu_shift_ctr #(
    .WIDTH (CTR_W),
    .MAX   (NORM_MAX)
  ) u_norm_ctr (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (!w_in_norm),
    .i_load     (1'b0),
    .i_load_val ({CTR_W{1'b0}}),
    .i_inc      (w_norm_left),
    .i_dec      (1'b0),
    .o_count    (w_norm_count),
    .o_zero     (w_norm_zero),
    .o_sat      (w_norm_sat)
  );

`ifdef FPU_SEQ_MUL_EN
  // Remaining extra EXEC cycles for a multiply.
  fpu_shift_ctr #(
    .WIDTH (MUL_W),
    .MAX   (MUL_CYCLES - 1)
  ) u_mul_ctr (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (1'b0),
    .i_load     (r_state == S_UNPACK),
    .i_load_val (MUL_W'(MUL_CYCLES - 1)),
    .i_inc      (1'b0),
    .i_dec      (r_state == S_EXEC),
    .o_count    (w_mul_count),
    .o_zero     (w_mul_zero),
    .o_sat      (w_mul_sat)
  );

  assign w_unused = ^{w_align_count, w_align_sat, w_norm_count, w_norm_zero,
                      w_mul_count, w_mul_sat};
`else
  assign w_unused = ^{w_align_count, w_align_sat, w_norm_count, w_norm_zero};
`endif

  // Control strobes decoded from the current state.
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.unpack_en   = (r_state == S_UNPACK);
  assign bus.align_shift = (r_state == S_ALIGN) && !w_align_zero;
  assign bus.exec_en     = (r_state == S_EXEC);
  assign bus.norm_left   = w_norm_left;
  assign bus.norm_right  = w_norm_right;
  assign bus.round_en    = (r_state == S_ROUND);
  assign bus.wb_en       = (r_state == S_WB) && !bus.flush;
  assign bus.done        = (r_state == S_WB) && !bus.flush;
  assign bus.result_sel  = r_result_sel;

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq. Each operation is expanded into a list
// of pipeline phases from its opcode, exponent difference and mantissa
// profile; that list supplies both the NORM-stage status inputs and the
// expected control strobes for every cycle.
module tb_fpu_seq;

`ifdef FPU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum {
    PH_UNPACK, PH_ASHIFT, PH_AIDLE, PH_EXEC, PH_NL, PH_NR, PH_NZ, PH_NEND,
    PH_ROUND, PH_WB
  } phase_e;

  typedef struct {
    phase_e     ph;
    logic       msb;
    logic       ovf;
    logic       zero;
    logic [1:0] res;
  } step_t;

  typedef struct {
    logic [1:0] op;
    int         ed;
    logic       special;
    int         n_ovf;
    int         k;
    bit         zero_end;
    int         flush_at;
    int         rst_at;
    bit         hold;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpu_seq_if bus ();

  fpu_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] exp_out = '0;
  logic        exp_valid = 1'b0;
  string       exp_tag = "init";
  int          txn_cyc = 0;
  int          done_seen = -1;
  step_t       plan[$];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {bus.busy, bus.done, bus.unpack_en, bus.align_shift, bus.exec_en,
            bus.norm_left, bus.norm_right, bus.round_en, bus.wb_en,
            bus.result_sel};
  endfunction

  function automatic txn_t mk(logic [1:0] op, int ed, logic special, int n_ovf,
                              int k, bit zero_end, int flush_at, int rst_at,
                              bit hold);
    txn_t t;
    t.op = op; t.ed = ed; t.special = special; t.n_ovf = n_ovf; t.k = k;
    t.zero_end = zero_end; t.flush_at = flush_at; t.rst_at = rst_at;
    t.hold = hold;
    return t;
  endfunction

  function automatic void push(phase_e ph, logic msb, logic ovf, logic zero,
                               logic [1:0] res);
    step_t s;
    s.ph = ph; s.msb = msb; s.ovf = ovf; s.zero = zero; s.res = res;
    plan.push_back(s);
  endfunction

  // Expand one operation into its cycle-by-cycle phase list. Outside NORM
  // the mantissa status is driven to misleading values on purpose.
  function automatic void build_plan(txn_t t);
    bit legal;
    int cap;
    int kk;
    plan.delete();
    legal = (t.op == 2'b00) || (t.op == 2'b01) || ((t.op == 2'b10) && MUL_EN);
    if (!legal) begin
      push(PH_WB, 1'b0, 1'b1, 1'b1, 2'b11);
      return;
    end
    push(PH_UNPACK, 1'b0, 1'b1, 1'b1, 2'b00);
    if (t.special) begin
      push(PH_WB, 1'b0, 1'b1, 1'b1, 2'b01);
      return;
    end
    if (t.op != 2'b10) begin
      cap = (t.ed > 25) ? 25 : t.ed;
      for (int i = 0; i < cap; i++) push(PH_ASHIFT, 1'b0, 1'b1, 1'b1, 2'b00);
      push(PH_AIDLE, 1'b0, 1'b1, 1'b1, 2'b00);
    end
    for (int i = 0; i < ((t.op == 2'b10) ? 4 : 1); i++)
      push(PH_EXEC, 1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < t.n_ovf; i++) push(PH_NR, 1'b0, 1'b1, 1'b0, 2'b00);
    kk = (t.k > 24) ? 24 : t.k;
    for (int i = 0; i < kk; i++) push(PH_NL, 1'b0, 1'b0, 1'b0, 2'b00);
    if (t.zero_end) begin
      push(PH_NZ, 1'b0, 1'b1, 1'b1, 2'b00);
      push(PH_WB, 1'b0, 1'b1, 1'b1, 2'b10);
    end else begin
      push(PH_NEND, (t.k > 24) ? 1'b0 : 1'b1, 1'b0, 1'b0, 2'b00);
      push(PH_ROUND, 1'b0, 1'b1, 1'b1, 2'b00);
      push(PH_WB, 1'b0, 1'b1, 1'b1, 2'b00);
    end
  endfunction

  function automatic logic [10:0] expect_of(step_t s, logic fl);
    logic wb;
    wb = (s.ph == PH_WB);
    return {1'b1, wb && !fl, s.ph == PH_UNPACK, s.ph == PH_ASHIFT,
            s.ph == PH_EXEC, s.ph == PH_NL, s.ph == PH_NR, s.ph == PH_ROUND,
            wb && !fl, wb ? s.res : 2'b00};
  endfunction

  // Single compare point: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      check($sformatf("%s c%0d", exp_tag, txn_cyc), 32'(dut_out()),
            32'(exp_out));
      if (bus.done) done_seen = txn_cyc;
    end
  end

  task automatic idle(input string tag, input int n);
    exp_tag = tag;
    bus.start = 1'b0; bus.flush = 1'b0; bus.special = 1'b1;
    bus.mant_msb = 1'b0; bus.mant_ovf = 1'b1; bus.mant_zero = 1'b1;
    exp_out = '0;
    for (int i = 0; i < n; i++) begin
      txn_cyc = i;
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; cycle 0 presents start.
  task automatic run_txn(input string tag, input txn_t t);
    int len;
    build_plan(t);
    len = plan.size();
    exp_tag = tag; done_seen = -1; txn_cyc = 0;
    bus.start = 1'b1; bus.op = t.op; bus.exp_diff = 8'(t.ed);
    bus.special = t.special; bus.flush = 1'b0;
    bus.mant_msb = 1'b0; bus.mant_ovf = 1'b1; bus.mant_zero = 1'b1;
    exp_out = '0;
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      logic fl;
      fl = (t.flush_at == i + 1);
      txn_cyc = i + 1;
      bus.start = t.hold;
      bus.op = ~t.op;
      bus.exp_diff = (i == 0) ? 8'(t.ed) : 8'hff;
      bus.special = (i == 0) ? t.special : 1'b1;
      bus.mant_msb = plan[i].msb;
      bus.mant_ovf = plan[i].ovf;
      bus.mant_zero = plan[i].zero;
      bus.flush = fl;
      exp_out = expect_of(plan[i], fl);
      if (t.rst_at == i + 1) begin
        exp_out = '0;
        #2 reset = 1'b0;
        #1 check({tag, " async_reset"}, 32'(dut_out()), 32'd0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (fl) break;
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.flush = 1'b0; bus.special = 1'b0;
    bus.exp_diff = 8'd0; bus.mant_msb = 1'b0; bus.mant_ovf = 1'b0;
    bus.mant_zero = 1'b0;
    #2 check("reset_outputs", 32'(dut_out()), 32'd0);
    exp_valid = 1'b1;
    // start is asserted while reset is held: it must be ignored.
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    idle("post_reset", 2);

    // Model pins: phase-list lengths for hand-derived latencies.
    build_plan(mk(2'b00, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("model_fadd_ed0_len", 32'(plan.size()), 32'd6);
    build_plan(mk(2'b00, 40, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("model_fadd_ed40_len", 32'(plan.size()), 32'd31);

    run_txn("fadd_ed0", mk(2'b00, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("fadd_ed0_done_cyc", 32'(done_seen), 32'd6);
    idle("gap1", 2);

    run_txn("fadd_ed40", mk(2'b00, 40, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("fadd_ed40_done_cyc", 32'(done_seen), 32'd31);
    idle("gap2", 1);

    run_txn("fmul_k3", mk(2'b10, 7, 1'b0, 0, 3, 1'b0, 0, 0, 1'b0));
    check("fmul_k3_done_cyc", 32'(done_seen), MUL_EN ? 32'd11 : 32'd1);
    idle("gap3", 1);

    run_txn("fmul_k0", mk(2'b10, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("fmul_k0_done_cyc", 32'(done_seen), MUL_EN ? 32'd8 : 32'd1);
    idle("gap4", 1);

    run_txn("fsub_special", mk(2'b01, 9, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0));
    check("fsub_special_done_cyc", 32'(done_seen), 32'd2);
    idle("gap5", 1);

    run_txn("fadd_zero", mk(2'b00, 3, 1'b0, 1, 0, 1'b1, 0, 0, 1'b0));
    check("fadd_zero_done_cyc", 32'(done_seen), 32'd9);
    idle("gap6", 1);

    run_txn("fsub_ovf_k2", mk(2'b01, 5, 1'b0, 2, 2, 1'b0, 0, 0, 1'b0));
    check("fsub_ovf_k2_done_cyc", 32'(done_seen), 32'd15);
    idle("gap7", 1);

    run_txn("fadd_k30_sat", mk(2'b00, 1, 1'b0, 0, 30, 1'b0, 0, 0, 1'b0));
    check("fadd_k30_done_cyc", 32'(done_seen), 32'd31);
    idle("gap8", 1);

    run_txn("illegal_op", mk(2'b11, 4, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("illegal_done_cyc", 32'(done_seen), 32'd1);
    idle("gap9", 1);

    // Back-to-back: start held through WB, next op accepted right after.
    run_txn("b2b_first", mk(2'b01, 2, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1));
    check("b2b_first_done_cyc", 32'(done_seen), 32'd8);
    run_txn("b2b_second", mk(2'b00, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0));
    check("b2b_second_done_cyc", 32'(done_seen), 32'd6);
    idle("gap10", 1);

    // Flush in EXEC (cycle 4 of an FADD with exp_diff=1).
    run_txn("flush_exec", mk(2'b00, 1, 1'b0, 0, 0, 1'b0, 4, 0, 1'b0));
    idle("after_flush", 8);
    check("flush_no_done", 32'(done_seen), 32'hffff_ffff);

    // Reset in the middle of ALIGN.
    run_txn("reset_align", mk(2'b00, 20, 1'b0, 0, 0, 1'b0, 0, 5, 1'b0));
    done_seen = -1;
    idle("in_reset", 2);
    reset = 1'b1;
    idle("after_reset", 35);
    check("reset_no_done", 32'(done_seen), 32'hffff_ffff);

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
